// File: rtl/tick_generator_pkg.sv
// tick_gen_pkg: shared types and helpers for the tick generator.
//   mode_e : channel output mode (pulse-only or square wave)
//   ch_w() : width of a channel index for n channels (minimum 1 bit)
package tick_gen_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_generator_channel.sv
// tick_channel: one divider channel of the tick generator.
//   clk, rst     : clock, synchronous active-high reset
//   en, clr      : count enable, synchronous restart (clr wins)
//   wr           : pending-config write strobe (already validated by top)
//   wr_div/mode  : new pending divisor / mode
//   tick         : one-cycle pulse after each wrap (registered)
//   sq           : square wave toggled on each wrap in square mode (registered)
// Config writes land in the pending registers only; they move to the
// active registers at a wrap, while disabled, or on clr.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] cnt, div_act, div_pend;
  mode_e            mode_act, mode_pend;
  logic             wrap;

  // >= rather than == so a divisor shrunk below the held count (loaded
  // while disabled) wraps on the next enabled edge instead of overflowing.
  assign wrap = (cnt >= (div_act - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div_act   <= DIV_RST;
      div_pend  <= DIV_RST;
      mode_act  <= MODE_PULSE;
      mode_pend <= MODE_PULSE;
      tick      <= 1'b0;
      sq        <= 1'b0;
    end else begin
      // Pending update uses the old pending value for any same-edge load
      // into active, so a write coincident with a wrap applies next wrap.
      if (wr) begin
        div_pend  <= wr_div;
        mode_pend <= mode_e'(wr_mode);
      end
      if (clr) begin
        cnt      <= '0;
        tick     <= 1'b0;
        sq       <= 1'b0;
        div_act  <= div_pend;
        mode_act <= mode_pend;
      end else if (!en) begin
        tick     <= 1'b0;
        div_act  <= div_pend;
        mode_act <= mode_pend;
      end else if (wrap) begin
        cnt      <= '0;
        tick     <= 1'b1;
        div_act  <= div_pend;
        mode_act <= mode_pend;
        sq       <= (mode_act == MODE_SQUARE) ? ~sq : 1'b0;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (mode_act == MODE_PULSE) sq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_generator.sv
// tick_generator: NCH independent programmable tick/square-wave dividers.
//   clk, rst   : clock, synchronous active-high reset
//   en, clr    : per-channel count enable / synchronous restart
//   cfg_we     : config write strobe; cfg_ch/cfg_div/cfg_mode = target, divisor, mode
//   tick, sq   : per-channel tick pulse and square wave (registered)
//   cfg_err    : one-cycle pulse for a write to a bad channel or zero divisor
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           en,
  input  logic [NCH-1:0]           clr,
  input  logic                     cfg_we,
  input  logic [ch_w(NCH)-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  input  logic                     cfg_mode,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           sq,
  output logic                     cfg_err
);

  localparam int CH_W = ch_w(NCH);

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $fatal(1, "tick_generator: NCH must be 1..16");
  end
  if (DIV_INIT < 1 || (CNT_W < 31 && DIV_INIT >= (1 << CNT_W))) begin : g_bad_div
    $fatal(1, "tick_generator: DIV_INIT out of range for CNT_W");
  end

  logic cfg_ok;
  assign cfg_ok = (32'(cfg_ch) < NCH) && (cfg_div != '0);

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .CNT_W   (CNT_W),
      .DIV_INIT(DIV_INIT)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .clr    (clr[g]),
      .wr     (cfg_we && cfg_ok && (cfg_ch == CH_W'(g))),
      .wr_div (cfg_div),
      .wr_mode(cfg_mode),
      .tick   (tick[g]),
      .sq     (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;
  import tick_gen_pkg::*;

  localparam int NCH = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en, clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   tick, sq;
  logic             cfg_err;

  int checks = 0;
  int failures = 0;
  int n;

  tick_generator #(.NCH(NCH), .CNT_W(CNT_W), .DIV_INIT(50)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .tick(tick), .sq(sq), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges until tick[ch] is seen (bounded); -1 on timeout.
  task automatic count_until(input int ch, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (tick[ch]) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
  endtask

  initial begin
    // Reset overrides en and a (bad) config write.
    rst = 1'b1; en = 3'b111; clr = 3'b000;
    cfg(2'd3, 16'd5, 1'b0);
    step(); step();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // Channel 0 alone: first tick after 50th edge, then every 50.
    rst = 1'b0; en = 3'b001; cfg_we = 1'b0;
    count_until(0, 60, n);
    chk("ch0_first", n, 32'd50);
    chk("ch0_first_vec", 32'(tick), 32'b001);
    chk("ch0_sq", 32'(sq), 32'd0);
    step();
    chk("ch0_one_cycle", 32'(tick), 32'd0);
    count_until(0, 60, n);
    chk("ch0_period", n + 1, 32'd50);

    // Channel 1 at cnt=10: write div=3 square; old period finishes first.
    en = 3'b011;
    repeat (10) step();
    cfg(2'd1, 16'd3, 1'b1);
    step();
    cfg_we = 1'b0;
    chk("valid_wr_no_err", 32'(cfg_err), 32'd0);
    count_until(1, 60, n);
    chk("ch1_wrap_after_wr", n + 1, 32'd40);
    chk("ch1_sq_still_low", 32'(sq[1]), 32'd0);
    count_until(1, 10, n);
    chk("ch1_new_period", n, 32'd3);
    chk("ch1_sq_high", 32'(sq[1]), 32'd1);
    count_until(1, 10, n);
    chk("ch1_period2", n, 32'd3);
    chk("ch1_sq_low", 32'(sq[1]), 32'd0);

    // Rejected writes: bad channel, zero divisor.
    cfg(2'd3, 16'd5, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("err_bad_ch", 32'(cfg_err), 32'd1);
    step();
    chk("err_one_cycle", 32'(cfg_err), 32'd0);
    cfg(2'd1, 16'd0, 1'b0);
    step();
    cfg_we = 1'b0;
    chk("err_zero_div", 32'(cfg_err), 32'd1);
    step();
    chk("err_clear2", 32'(cfg_err), 32'd0);
    count_until(1, 10, n);
    count_until(1, 10, n);
    chk("ch1_unchanged_by_err", n, 32'd3);

    // Channel 0: pause 10 cycles at cnt=20, then clr at cnt=40.
    count_until(0, 60, n);
    repeat (20) step();
    en = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ch0_paused_no_tick", 32'(tick[0]), 32'd0);
    end
    en = 3'b011;
    count_until(0, 60, n);
    chk("ch0_after_pause", n, 32'd30);
    repeat (40) step();
    clr = 3'b001;
    step();
    clr = 3'b000;
    chk("clr_tick", 32'(tick[0]), 32'd0);
    chk("clr_sq", 32'(sq[0]), 32'd0);
    count_until(0, 60, n);
    chk("ch0_after_clr", n, 32'd50);

    // Channel 2 div=1 written at cnt=5; current period ends first.
    en = 3'b111;
    repeat (5) step();
    cfg(2'd2, 16'd1, 1'b0);
    step();
    cfg_we = 1'b0;
    count_until(2, 60, n);
    chk("ch2_wrap", n, 32'd44);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ch2_const_high", 32'(tick[2]), 32'd1);
    end

    // Pending ch0 write then reset: write discarded, all back to 50.
    cfg(2'd0, 16'd7, 1'b1);
    step();
    rst = 1'b1;
    cfg(2'd3, 16'd9, 1'b0);
    step();
    rst = 1'b0; cfg_we = 1'b0;
    chk("rst2_tick", 32'(tick), 32'd0);
    chk("rst2_sq", 32'(sq), 32'd0);
    chk("rst2_err", 32'(cfg_err), 32'd0);
    count_until(0, 60, n);
    chk("rst2_ch0_div50", n, 32'd50);
    chk("rst2_all_tick", 32'(tick), 32'b111);
    step();
    chk("rst2_ch2_not_div1", 32'(tick), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
